// File: rtl/jtag_tap_slave.sv
// jtag_tap_slave: IEEE 1149.1 TAP responder running on the system clock.
// The JTAG pins are oversampled and tck edges become single-clk strobes.
// Supports BYPASS, IDCODE and a 32-bit USER read/write mailbox.
`timescale 1ns/1ps
module jtag_tap_slave #(
    parameter logic [31:0] IDCODE    = 32'h1000_0001,
    parameter logic [3:0]  IR_IDCODE = 4'h1,
    parameter logic [3:0]  IR_USER   = 4'h8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tck,
    input  logic        tms,
    input  logic        tdi,
    output logic        tdo,
    output logic        tdo_oe,
    input  logic [31:0] user_din,
    output logic [31:0] user_dout,
    output logic        user_capture,
    output logic        user_update,
    output logic [3:0]  tap_state
);

    // TAP state encoding (matches the 1149.1 reference encoding)
    localparam logic [3:0] S_TLR     = 4'hF;
    localparam logic [3:0] S_RTI     = 4'hC;
    localparam logic [3:0] S_SEL_DR  = 4'h7;
    localparam logic [3:0] S_CAP_DR  = 4'h6;
    localparam logic [3:0] S_SH_DR   = 4'h2;
    localparam logic [3:0] S_EX1_DR  = 4'h1;
    localparam logic [3:0] S_PAU_DR  = 4'h3;
    localparam logic [3:0] S_EX2_DR  = 4'h0;
    localparam logic [3:0] S_UPD_DR  = 4'h5;
    localparam logic [3:0] S_SEL_IR  = 4'h4;
    localparam logic [3:0] S_CAP_IR  = 4'hE;
    localparam logic [3:0] S_SH_IR   = 4'hA;
    localparam logic [3:0] S_EX1_IR  = 4'h9;
    localparam logic [3:0] S_PAU_IR  = 4'hB;
    localparam logic [3:0] S_EX2_IR  = 4'h8;
    localparam logic [3:0] S_UPD_IR  = 4'hD;

    logic [2:0]  r_tck_sync;
    logic [1:0]  r_tms_sync;
    logic [1:0]  r_tdi_sync;
    logic [3:0]  r_state;
    logic [3:0]  w_next_state;
    logic [3:0]  r_ir;
    logic [3:0]  r_ir_sr;
    logic [31:0] r_dr_sr;
    logic [31:0] r_user_dout;
    logic        r_user_capture;
    logic        r_user_update;
    logic        r_tdo;
    logic        r_tdo_oe;

    logic w_tck_rise;
    logic w_tck_fall;
    logic w_tms;
    logic w_tdi;
    logic w_sel_user;
    logic w_sel_idcode;

    // tms/tdi use the same depth as tck's first two flops, so the values
    // seen with a strobe are the pin values at the tck pad edge.
    assign w_tck_rise   = r_tck_sync[1] & ~r_tck_sync[2];
    assign w_tck_fall   = ~r_tck_sync[1] & r_tck_sync[2];
    assign w_tms        = r_tms_sync[1];
    assign w_tdi        = r_tdi_sync[1];
    assign w_sel_user   = (r_ir == IR_USER);
    assign w_sel_idcode = (r_ir == IR_IDCODE);

    assign tdo          = r_tdo;
    assign tdo_oe       = r_tdo_oe;
    assign user_dout    = r_user_dout;
    assign user_capture = r_user_capture;
    assign user_update  = r_user_update;
    assign tap_state    = r_state;

    // Synchronise the JTAG pins and keep one extra tck flop for edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tck_sync <= 3'b000;
            r_tms_sync <= 2'b00;
            r_tdi_sync <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge value, which is what makes this a real shift chain.
            r_tck_sync <= {r_tck_sync[1:0], tck};
            r_tms_sync <= {r_tms_sync[0], tms};
            r_tdi_sync <= {r_tdi_sync[0], tdi};
        end
    end

    // Standard 1149.1 next-state function driven by synchronised tms
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            S_TLR:    w_next_state = w_tms ? S_TLR    : S_RTI;
            S_RTI:    w_next_state = w_tms ? S_SEL_DR : S_RTI;
            S_SEL_DR: w_next_state = w_tms ? S_SEL_IR : S_CAP_DR;
            S_CAP_DR: w_next_state = w_tms ? S_EX1_DR : S_SH_DR;
            S_SH_DR:  w_next_state = w_tms ? S_EX1_DR : S_SH_DR;
            S_EX1_DR: w_next_state = w_tms ? S_UPD_DR : S_PAU_DR;
            S_PAU_DR: w_next_state = w_tms ? S_EX2_DR : S_PAU_DR;
            S_EX2_DR: w_next_state = w_tms ? S_UPD_DR : S_SH_DR;
            S_UPD_DR: w_next_state = w_tms ? S_SEL_DR : S_RTI;
            S_SEL_IR: w_next_state = w_tms ? S_TLR    : S_CAP_IR;
            S_CAP_IR: w_next_state = w_tms ? S_EX1_IR : S_SH_IR;
            S_SH_IR:  w_next_state = w_tms ? S_EX1_IR : S_SH_IR;
            S_EX1_IR: w_next_state = w_tms ? S_UPD_IR : S_PAU_IR;
            S_PAU_IR: w_next_state = w_tms ? S_EX2_IR : S_PAU_IR;
            S_EX2_IR: w_next_state = w_tms ? S_UPD_IR : S_SH_IR;
            S_UPD_IR: w_next_state = w_tms ? S_SEL_DR : S_RTI;
            default:  w_next_state = S_TLR;
        endcase
    end

    // Advance the TAP state only on a tck rising strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_TLR;
        end else if (w_tck_rise) begin
            r_state <= w_next_state;
        end
    end

    // Instruction register: capture/shift on rise, update on fall, TLR forces IDCODE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ir_sr <= 4'b0000;
            r_ir    <= IR_IDCODE;
        end else begin
            if (w_tck_rise) begin
                if (r_state == S_CAP_IR) begin
                    r_ir_sr <= 4'b0001;
                end else if (r_state == S_SH_IR) begin
                    r_ir_sr <= {w_tdi, r_ir_sr[3:1]};
                end
            end
            if (r_state == S_TLR) begin
                r_ir <= IR_IDCODE;
            end else if (w_tck_fall && (r_state == S_UPD_IR)) begin
                r_ir <= r_ir_sr;
            end
        end
    end

    // Data register path and USER mailbox with single-clk capture/update pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dr_sr        <= 32'h0;
            r_user_dout    <= 32'h0;
            r_user_capture <= 1'b0;
            r_user_update  <= 1'b0;
        end else begin
            r_user_capture <= 1'b0;
            r_user_update  <= 1'b0;
            if (w_tck_rise) begin
                if (r_state == S_CAP_DR) begin
                    if (w_sel_user) begin
                        r_dr_sr        <= user_din;
                        r_user_capture <= 1'b1;
                    end else if (w_sel_idcode) begin
                        r_dr_sr <= IDCODE;
                    end else begin
                        r_dr_sr <= 32'h0;
                    end
                end else if (r_state == S_SH_DR) begin
                    // Unknown opcodes fall through to the 1-bit bypass path
                    if (w_sel_user || w_sel_idcode) begin
                        r_dr_sr <= {w_tdi, r_dr_sr[31:1]};
                    end else begin
                        r_dr_sr <= {r_dr_sr[31:1], w_tdi};
                    end
                end
            end
            if (w_tck_fall && (r_state == S_UPD_DR) && w_sel_user) begin
                r_user_dout   <= r_dr_sr;
                r_user_update <= 1'b1;
            end
        end
    end

    // Drive tdo and its enable from the falling strobe so they hold across the next rise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tdo    <= 1'b0;
            r_tdo_oe <= 1'b0;
        end else if (w_tck_fall) begin
            if (r_state == S_SH_IR) begin
                r_tdo    <= r_ir_sr[0];
                r_tdo_oe <= 1'b1;
            end else if (r_state == S_SH_DR) begin
                r_tdo    <= r_dr_sr[0];
                r_tdo_oe <= 1'b1;
            end else begin
                r_tdo    <= 1'b0;
                r_tdo_oe <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jtag_tap_slave.sv
// tb_jtag_tap_slave: directed JTAG scans against jtag_tap_slave.
// Stimulus pushes the expected tdo bit stream into a queue; a monitor pops
// and compares one bit on every tck rise while tdo_oe is high.
`timescale 1ns/1ps
module tb_jtag_tap_slave;

    localparam logic [31:0] IDCODE = 32'h1000_0001;

    logic        clk = 1'b0;
    logic        rst;
    logic        tck;
    logic        tms;
    logic        tdi;
    logic        tdo;
    logic        tdo_oe;
    logic [31:0] user_din;
    logic [31:0] user_dout;
    logic        user_capture;
    logic        user_update;
    logic [3:0]  tap_state;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic exp_q[$];
    logic mon_exp;
    int   upd_cnt = 0;
    int   cap_cnt = 0;
    logic prev_upd = 1'b0;
    logic prev_cap = 1'b0;

    jtag_tap_slave #(
        .IDCODE    (IDCODE),
        .IR_IDCODE (4'h1),
        .IR_USER   (4'h8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tck          (tck),
        .tms          (tms),
        .tdi          (tdi),
        .tdo          (tdo),
        .tdo_oe       (tdo_oe),
        .user_din     (user_din),
        .user_dout    (user_dout),
        .user_capture (user_capture),
        .user_update  (user_update),
        .tap_state    (tap_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: the master samples tdo on each tck rise while the DUT drives it
    always @(posedge tck) begin
        if (tdo_oe === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL tdo_extra: got tdo=%b expected no shifted bit", tdo);
            end else begin
                mon_exp = exp_q.pop_front();
                check("tdo_bit", {31'b0, tdo}, {31'b0, mon_exp});
            end
        end
    end

    // Count mailbox pulses and flag any that last longer than one clk
    always @(negedge clk) begin
        if (user_update === 1'b1) begin
            upd_cnt++;
            check("update_width", {31'b0, prev_upd}, 32'h0);
        end
        if (user_capture === 1'b1) begin
            cap_cnt++;
            check("capture_width", {31'b0, prev_cap}, 32'h0);
        end
        prev_upd = user_update;
        prev_cap = user_capture;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tck_pulse(input logic tms_v, input logic tdi_v);
        @(posedge clk); #2;
        tms = tms_v;
        tdi = tdi_v;
        repeat (6) @(posedge clk);
        #2 tck = 1'b1;
        repeat (6) @(posedge clk);
        #2 tck = 1'b0;
    endtask

    task automatic goto_tlr();
        for (int i = 0; i < 5; i++) tck_pulse(1'b1, 1'b0);
    endtask

    // From RTI: SelDR, CapDR, ShDR
    task automatic enter_dr();
        tck_pulse(1'b1, 1'b0);
        tck_pulse(1'b0, 1'b0);
        tck_pulse(1'b0, 1'b0);
    endtask

    task automatic shift_bits(input logic [31:0] din, input logic [31:0] exp,
                              input int n, input logic exit_last);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(exp[i]);
            tck_pulse(exit_last && (i == n - 1), din[i]);
        end
    endtask

    // From RTI: full DR scan ending back in RTI via UpdDR
    task automatic shift_dr(input logic [31:0] din, input logic [31:0] exp, input int n);
        enter_dr();
        shift_bits(din, exp, n, 1'b1);
        tck_pulse(1'b1, 1'b0);
        tck_pulse(1'b0, 1'b0);
    endtask

    // From RTI: IR scan; the captured pattern 0001 always comes out first
    task automatic shift_ir(input logic [3:0] v);
        tck_pulse(1'b1, 1'b0);
        tck_pulse(1'b1, 1'b0);
        tck_pulse(1'b0, 1'b0);
        tck_pulse(1'b0, 1'b0);
        shift_bits({28'h0, v}, 32'h1, 4, 1'b1);
        tck_pulse(1'b1, 1'b0);
        tck_pulse(1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; tck = 1'b0; tms = 1'b1; tdi = 1'b0; user_din = 32'h0;
        repeat (3) @(posedge clk); #2;
        check("rst_state", {28'h0, tap_state}, 32'hF);
        check("rst_tdo", {30'h0, tdo_oe, tdo}, 32'h0);
        check("rst_user", {user_dout[29:0], user_capture, user_update}, 32'h0);
        rst = 1'b0;

        // IDCODE scan with state-sequence checks
        goto_tlr();
        check("tlr_state", {28'h0, tap_state}, 32'hF);
        tck_pulse(1'b0, 1'b0); check("state_rti",   {28'h0, tap_state}, 32'hC);
        tck_pulse(1'b1, 1'b0); check("state_seldr", {28'h0, tap_state}, 32'h7);
        tck_pulse(1'b0, 1'b0); check("state_capdr", {28'h0, tap_state}, 32'h6);
        tck_pulse(1'b0, 1'b0); check("state_shdr",  {28'h0, tap_state}, 32'h2);
        shift_bits(32'h0, IDCODE, 32, 1'b1);
        check("state_ex1dr", {28'h0, tap_state}, 32'h1);
        tck_pulse(1'b1, 1'b0);
        tck_pulse(1'b0, 1'b0);
        check("state_rti2", {28'h0, tap_state}, 32'hC);

        // IR capture readback, then BYPASS via IR=F: tdi 1,0,1,1,0 -> tdo 0,1,0,1,1
        shift_ir(4'hF);
        shift_dr(32'h0000_000D, 32'h0000_001A, 5);

        // USER write then USER read
        shift_ir(4'h8);
        user_din = 32'h0;
        shift_dr(32'hDEAD_BEEF, 32'h0, 32);
        repeat (4) @(posedge clk); #2;
        check("user_dout_wr", user_dout, 32'hDEAD_BEEF);
        check("update_cnt1", upd_cnt, 1);
        check("capture_cnt1", cap_cnt, 1);
        user_din = 32'h1234_5678;
        shift_dr(32'hA5A5_5A5A, 32'h1234_5678, 32);
        repeat (4) @(posedge clk); #2;
        check("capture_cnt2", cap_cnt, 2);
        check("update_cnt2", upd_cnt, 2);
        check("user_dout_wr2", user_dout, 32'hA5A5_5A5A);

        // TLR forces IR back to IDCODE; mailbox untouched
        shift_ir(4'h8);
        goto_tlr();
        check("tlr_state2", {28'h0, tap_state}, 32'hF);
        tck_pulse(1'b0, 1'b0);
        shift_dr(32'hFFFF_FFFF, IDCODE, 32);
        repeat (4) @(posedge clk); #2;
        check("user_dout_keep", user_dout, 32'hA5A5_5A5A);
        check("update_cnt3", upd_cnt, 2);

        // Reset in the middle of a USER shift aborts it
        shift_ir(4'h8);
        user_din = 32'hCAFE_F00D;
        enter_dr();
        shift_bits(32'h0000_FFFF, 32'hCAFE_F00D, 17, 1'b0);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("midrst_state", {28'h0, tap_state}, 32'hF);
        check("midrst_tdo", {30'h0, tdo_oe, tdo}, 32'h0);
        check("midrst_user", user_dout, 32'h0);
        repeat (2) @(posedge clk); #2;
        rst = 1'b0;
        goto_tlr();
        tck_pulse(1'b0, 1'b0);
        shift_dr(32'h0, IDCODE, 32);
        repeat (4) @(posedge clk); #2;
        check("postrst_user", user_dout, 32'h0);
        check("postrst_update", upd_cnt, 2);
        check("postrst_capture", cap_cnt, 3);

        // Unimplemented opcode behaves as BYPASS
        shift_ir(4'h5);
        shift_dr(32'h0000_000D, 32'h0000_001A, 5);
        repeat (4) @(posedge clk); #2;
        check("unimpl_user", user_dout, 32'h0);
        check("unimpl_update", upd_cnt, 2);

        check("tdo_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jtag_tap_slave.md
# jtag_tap_slave

Synthesizable IEEE 1149.1 TAP responder that sits on the device side of the JTAG link and answers the TCK/TMS/TDI stream produced by the VPI JTAG driver. It oversamples the JTAG pins on the system clock and runs the 16-state TAP controller. It implements a 4-bit instruction register with BYPASS, IDCODE and a 32-bit USER data register. The USER register gives the debug server a read/write mailbox into on-chip logic.

## Interface
- `IDCODE`, default 32'h1000_0001: value captured in Capture-DR when IR=IDCODE; bit 0 must be 1.
- `IR_IDCODE`, default 4'h1: IDCODE opcode; also the IR reset value.
- `IR_USER`, default 4'h8: USER opcode.
- `clk` input 1: system clock; all state is clocked on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `tck` input 1: JTAG clock, asynchronous to `clk`, oversampled.
- `tms` input 1: JTAG mode select, oversampled.
- `tdi` input 1: JTAG data in, oversampled.
- `tdo` output 1: JTAG data out.
- `tdo_oe` output 1: high while in Shift-DR/Shift-IR.
- `user_din` input 32: value loaded into the shift register in Capture-DR when IR=USER.
- `user_dout` output 32: USER register, written at Update-DR.
- `user_capture` output 1: one-`clk` pulse when `user_din` is sampled.
- `user_update` output 1: one-`clk` pulse when `user_dout` changes.
- `tap_state` output 4: current TAP state encoding.

## Operation
- Sync: `tck`, `tms`, `tdi` each pass through 2 flops. A third flop on `tck` gives the edge detect: `tck_rise`/`tck_fall` are single-`clk` strobes.
- State encoding (hex): TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauseDR 3, Ex2DR 0, UpdDR 5, SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauseIR B, Ex2IR 8, UpdIR D.
- Transitions: standard 1149.1, advanced only on `tck_rise` using the synchronized `tms`.
- Actions on `tck_rise`, evaluated in the current state before the transition:
  - CapIR: `ir_sr` <= 4'b0001.
  - ShIR: `ir_sr` <= {tdi, ir_sr[3:1]}.
  - CapDR: `dr_sr` <= IDCODE, {31'b0,0} for BYPASS, or `user_din` for USER. USER also pulses `user_capture`.
  - ShDR: shift right with `tdi` into the MSB of the selected length (32 for IDCODE/USER, 1 for BYPASS).
- Actions on `tck_fall`:
  - UpdIR: `ir` <= `ir_sr`.
  - UpdDR with `ir`==IR_USER: `user_dout` <= `dr_sr` and pulse `user_update`.
  - `tdo` <= `ir_sr[0]` in ShIR, `dr_sr[0]` in ShDR, else 0.
  - `tdo_oe` <= 1 in ShIR/ShDR, else 0.
- Unimplemented opcodes select BYPASS.
- While in TLR, `ir` is forced to IR_IDCODE every `clk`.
- Async `rst`:
  - state=TLR, `ir`=IR_IDCODE.
  - `ir_sr`=0, `dr_sr`=0, `user_dout`=0.
  - `tdo`=0, `tdo_oe`=0, `user_capture`=0, `user_update`=0.
  - sync flops cleared.
- `rst` mid-shift aborts the shift; no update occurs.

## Timing
- Pin-to-strobe latency: 3 `clk` from a `tck` pad edge to `tck_rise`/`tck_fall`. `tms`/`tdi` use equal depth, so they are sampled as they were at the edge.
- Requirement: each `tck` high and low phase is at least 4 `clk` periods (10 MHz TCK with 100 MHz clk is valid). `tms`/`tdi` stable ±2 `clk` around the `tck` rising edge.
- `tdo` changes 1 `clk` after `tck_fall` and is valid to the master on the next `tck` rise.
- The first bit appears on `tdo` after the falling edge that follows the CapDR→ShDR rise.
- `tap_state` updates 1 `clk` after `tck_rise`.
- `user_update`/`user_capture`: exactly 1 `clk` wide, 1 `clk` after the strobe.
- Reset to TLR: 5 TCK cycles with TMS=1 from any state.

## Test plan
- After `rst`, 5 TCK with TMS=1, then TMS 0,1,0,0 → ShDR. Shift 32 bits with TDI=0 → TDO reads 0x10000001 LSB first; `tap_state` sequence C,7,6,2.
- Go to ShIR and shift 4 bits → TDO 1,0,0,0 (capture 0001). Load 4'hF and Update-IR, then shift DR with TDI 1,0,1,1,0 → TDO 0,1,0,1,1 (one-bit delay).
- Load IR=8, shift 0xDEADBEEF through ShDR→Ex1DR→UpdDR → `user_dout`=0xDEADBEEF with a single `user_update` pulse. Next scan with `user_din`=0x12345678 → TDO returns 0x12345678 and `user_capture` pulses once.
- Load IR=8, then 5×TMS=1 → `tap_state`=F, `ir`=1. A following DR scan returns IDCODE and `user_dout` is unchanged.
- Assert `rst` at bit 17 of a USER shift → outputs return to reset values immediately. After re-entry to ShDR the IDCODE scan is correct.
- Load IR=4'h5 (unimplemented) → a DR scan behaves as BYPASS with one-bit delay.
